// File: rtl/dir_select_ctrl.sv
// dir_select_ctrl: synchronises and debounces up/down buttons into a registered direction level
module dir_select_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic Clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic x,
  output logic x_chg,
  output logic lock,
  output logic up_db,
  output logic down_db
);
  typedef enum logic [1:0] {S_DOWN, S_UP, S_LOCK} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state_q;
  logic [1:0] s1_q, s2_q, db_q, dbp_q, press;
  logic [CNT_W-1:0] cnt_q [2];
  logic x_q, x_chg_q, lock_q, lock_in;
  assign press = db_q & ~dbp_q;
  // a press while the other button is already held (or pressed together) is ambiguous
  assign lock_in = (press[0] & db_q[1]) | (press[1] & db_q[0]);
  always_ff @(posedge Clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      dbp_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q <= {btn_down, btn_up};
      s2_q <= s1_q;
      dbp_q <= db_q;
      for (int i = 0; i < 2; i++)
        if (s2_q[i] == db_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == LAST) begin
          db_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_DOWN;
      x_q <= 1'b0;
      x_chg_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      x_chg_q <= 1'b0;
      if (state_q == S_LOCK) begin
        if (db_q == 2'b00) begin
          state_q <= x_q ? S_UP : S_DOWN;
          lock_q <= 1'b0;
        end
      end else if (lock_in) begin
        state_q <= S_LOCK;
        lock_q <= 1'b1;
      end else if (state_q == S_DOWN && press[0]) begin
        state_q <= S_UP;
        x_q <= 1'b1;
        x_chg_q <= 1'b1;
      end else if (state_q == S_UP && press[1]) begin
        state_q <= S_DOWN;
        x_q <= 1'b0;
        x_chg_q <= 1'b1;
      end
    end
  end
  assign x = x_q;
  assign x_chg = x_chg_q;
  assign lock = lock_q;
  assign up_db = db_q[0];
  assign down_db = db_q[1];
endmodule

// File: doc/dir_select_ctrl.md
Name: dir_select_ctrl

Overview:
Upstream conditioning stage for the 2-bit direction counter. It takes two raw push-button inputs, btn_up and btn_down, and synchronises and debounces them. It then turns the presses into a registered direction level x, which drives the counter's x input directly. A lock state handles simultaneous presses, and a one-cycle change pulse is provided for display logic.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles required before a debounced level changes (legal range 1..7)
CNT_W, 3, width of each debounce counter; must hold DEBOUNCE_CYCLES-1

Ports:
Clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
btn_up  input  1  raw, asynchronous, bouncing "count up" button
btn_down  input  1  raw, asynchronous, bouncing "count down" button
x  output  1  registered direction to counter: 1 = up, 0 = down
x_chg  output  1  one-cycle pulse, high in the first cycle x holds a new value
lock  output  1  high while FSM is in LOCK state
up_db  output  1  debounced btn_up level
down_db  output  1  debounced btn_down level

Behaviour:
- Reset: synchronous, active-high, one clock, sampled on the Clk rising edge. Takes priority over all other activity, including reset mid-debounce or mid-lock. After reset:
  - sync flops, debounce counters, up_db, down_db and edge-detect registers = 0
  - FSM = S_DOWN, x = 0, x_chg = 0, lock = 0
- Synchroniser: each button passes through 2 flops (s1, s2). The edge sampling raw into s1 is edge k; s2 shows the value after edge k+1.
- Debounce, per button, every edge:
  - s2 == db: cnt <= 0
  - s2 != db and cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0
  - otherwise: cnt <= cnt+1
  - Any bounce back to db restarts the count from 0.
- Press detect: press = db & ~db_prev, where db_prev is db delayed one cycle. Releases generate no event.
- FSM states S_DOWN (x=0), S_UP (x=1), S_LOCK (x holds last value, lock=1). On each edge, by priority:
  1. reset -> S_DOWN.
  2. From S_UP or S_DOWN: press_up and press_down in the same cycle -> S_LOCK.
  3. S_DOWN and press_up -> S_UP.
  4. S_UP and press_down -> S_DOWN.
  5. A press matching the current direction -> no change, no x_chg.
  6. S_LOCK: stays while up_db or down_db = 1. When both are 0 -> returns to the state matching the held x, no x_chg. Presses in LOCK are ignored.
- Lock entry also occurs when one button is already debounced-high and the other produces a press: press_x with the other db = 1 -> S_LOCK.
- x_chg = 1 exactly in the cycle after the edge where x toggled. Never asserted on reset or LOCK entry/exit.
- Latency: a clean level change sampled first at edge k changes db at edge k+1+DEBOUNCE_CYCLES, and changes x at edge k+2+DEBOUNCE_CYCLES. For the default this is edge k+6.
- Pulses narrower than DEBOUNCE_CYCLES cycles at s2 are fully rejected: db, x and x_chg are unchanged.
- Holding a button produces exactly one press; there is no auto-repeat.
- All outputs are registered. There are no combinational paths from btn_* to any output.

Test Plan:
1. Reset, then hold both buttons at 0 for 20 cycles -> x=0, x_chg=0, lock=0, up_db=down_db=0 throughout.
2. Raise btn_up cleanly before edge k and hold (DEBOUNCE_CYCLES=4) -> up_db=1 after edge k+5; x=1 after edge k+6; x_chg=1 for exactly that one cycle; holding 30 more cycles gives no further x_chg.
3. Bouncing btn_down with pattern 1,0,1,1,0 (one cycle each), then steady 1 while in S_UP -> no change during the bounce; x=0 exactly 6 edges after the first sample of the steady 1; a single x_chg pulse.
4. In S_DOWN, btn_up and btn_down rise on the same edge -> lock=1 at edge k+6 and x stays 0. Release both; after the debounce settles, lock=0, x=0, and no x_chg in the whole sequence.
5. Hold btn_up (x=1), then press btn_down -> lock=1 and x stays 1. Release btn_up only -> stays locked. Release btn_down -> lock=0, x=1.
6. Assert reset for one cycle while x=1 and the debounce count is mid-way -> next cycle x=0, lock=0, counters cleared. A press already in progress must then be re-qualified for the full DEBOUNCE_CYCLES.
